// File: rtl/adder_tree_pkg.sv
// Shared widths, FSM encoding and default scaling/clamp constants for the
// kernel-window adder tree accumulator.
package adder_tree_pkg;

  localparam int GAIN_DEFAULT      = 251;
  localparam int CLAMP_MAX_DEFAULT = 253;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic int product_w(input int data_w, input int weight_w);
    return data_w + weight_w;
  endfunction

  function automatic int row_w(input int data_w, input int weight_w, input int k);
    return product_w(data_w, weight_w) + $clog2(k);
  endfunction

  function automatic int acc_w(input int data_w, input int weight_w, input int k);
    return product_w(data_w, weight_w) + $clog2(k * k);
  endfunction

endpackage

// File: rtl/row_adder.sv
// Combinational sum of N packed unsigned operands; the output width is chosen
// by the caller so that no carry is lost.
module row_adder #(
  parameter int N     = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 18
) (
  input  logic [N*IN_W-1:0] operands_i,
  output logic [OUT_W-1:0]  sum_o
);

  always_comb begin
    sum_o = '0;
    for (int j = 0; j < N; j++) begin
      sum_o = sum_o + OUT_W'(operands_i[j*IN_W +: IN_W]);
    end
  end

endmodule

// File: rtl/adder_tree_accum.sv
// Accumulates KERNEL_SIZE rows of products into one window sum, then scales
// and clamps it into a pixel that is held until the consumer takes it.
//   state    | meaning
//   ST_ACCUM | accepting rows of the current window
//   ST_DRAIN | last row taken, waiting for the pipeline to finish the sum
//   ST_HOLD  | result presented, waiting for out_ready
module adder_tree_accum
  import adder_tree_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int GAIN         = GAIN_DEFAULT,
  parameter int CLAMP_MAX    = CLAMP_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic mode,
  input  logic in_valid,
  output logic in_ready,
  input  logic [KERNEL_SIZE*product_w(DATA_WIDTH, WEIGHT_WIDTH)-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [acc_w(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)-1:0] out_raw,
  output logic [DATA_WIDTH-1:0] out_pix,
  output logic out_sat
);

  localparam int PRODUCT_W = product_w(DATA_WIDTH, WEIGHT_WIDTH);
  localparam int ROW_W     = row_w(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
  localparam int ACC_W     = acc_w(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
  localparam int CNT_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int GAIN_W    = $clog2(GAIN + 1);
  localparam int MUL_W     = ACC_W + GAIN_W;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(KERNEL_SIZE - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             row_take;

  logic [KERNEL_SIZE*PRODUCT_W-1:0] s1_data_q;
  logic                             s1_valid_q, s1_first_q, s1_last_q;

  logic [ROW_W-1:0] row_sum;
  logic [ROW_W-1:0] s2_sum_q;
  logic             s2_valid_q, s2_first_q, s2_last_q;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             done_q, done_d;

  logic [MUL_W-1:0]      prod_full, scaled, sel;
  logic                  sel_sat;
  logic [DATA_WIDTH-1:0] pix_d;
  logic                  out_load;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  // clear wins over a simultaneous row: the row never enters the pipeline
  assign row_take  = in_valid && in_ready && !clear;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (row_take) begin
      cnt_d = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= row_take;
      if (row_take) begin
        s1_data_q  <= in_data;
        s1_first_q <= (cnt_q == '0);
        s1_last_q  <= (cnt_q == LAST_ROW);
      end
    end
  end

  row_adder #(
    .N     (KERNEL_SIZE),
    .IN_W  (PRODUCT_W),
    .OUT_W (ROW_W)
  ) u_row_adder (
    .operands_i (s1_data_q),
    .sum_o      (row_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
    end else if (clear) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q   <= row_sum;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
    end
  end

  always_comb begin
    acc_d  = acc_q;
    done_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (s2_valid_q) begin
      acc_d  = s2_first_q ? ACC_W'(s2_sum_q) : acc_q + ACC_W'(s2_sum_q);
      done_d = s2_last_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      done_q <= done_d;
    end
  end

  // Scaling by GAIN/256 is done at full width so the clamp sees the true value.
  assign prod_full = MUL_W'(acc_q) * MUL_W'(GAIN);
  assign scaled    = prod_full >> 8;
  assign sel       = mode ? scaled : MUL_W'(acc_q);
  assign sel_sat   = (sel > MUL_W'(CLAMP_MAX));
  assign pix_d     = sel_sat ? DATA_WIDTH'(CLAMP_MAX) : sel[DATA_WIDTH-1:0];
  assign out_load  = done_q && (state_q == ST_DRAIN) && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_raw <= '0;
      out_pix <= '0;
      out_sat <= 1'b0;
    end else if (out_load) begin
      out_raw <= acc_q;
      out_pix <= pix_d;
      out_sat <= sel_sat;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (row_take && (cnt_q == LAST_ROW)) state_d = ST_DRAIN;
      ST_DRAIN: if (done_q) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
    if (clear) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
